ahbmtx_addr_decoder: RTL and testbench

AHBMTX_ADDR_DECODER -- requirements
Module: ahbmtx_addr_decoder

---
 rtl/ahbmtx_pkg.sv | 27 ++
 rtl/ahbmtx_addr_decoder_default_slave.sv | 56 +++++
 rtl/ahbmtx_addr_decoder.sv | 111 +++++++++++
 tb/tb_ahbmtx_addr_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbmtx_pkg.sv
// Shared AHB matrix definitions: transfer/response encodings and decoder sizing.
package ahbmtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam int NUM_SLAVES   = 4;
    localparam int DATA_W       = 32;
    localparam int DECERR_CNT_W = 8;

    // True for transfer types that carry data and therefore need a response.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbmtx_addr_decoder_default_slave.sv
// Default slave for unmapped regions: zero-wait OKAY for IDLE/BUSY,
// two-cycle ERROR response for NONSEQ/SEQ.
module AhbMtx_default_slave
    import ahbmtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic [1:0] HRESP
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    ds_state_e state, state_nxt;
    logic      accept;

    assign accept = HSEL && HREADY && is_active_trans(HTRANS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ERR2 completes the error while HREADY is high, so a new access may start there.
    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (accept) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP     = HRESP_ERROR;
                state_nxt = accept ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahbmtx_addr_decoder.sv
// AHB address decoder with data-phase response mux, internal default slave and
// decode-error counter. Define AHBMTX_DEC_REMAP_EN to let REMAP alias region 0 to slave 1.
module ahbmtx_addr_decoder
    import ahbmtx_pkg::*;
#(
    parameter logic [3:0] S0_BASE = 4'h0,
    parameter logic [3:0] S1_BASE = 4'h2,
    parameter logic [3:0] S2_BASE = 4'h4,
    parameter logic [3:0] S3_BASE = 4'h5
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic [31:0]                    HADDR,
    input  logic [1:0]                     HTRANS,
    input  logic                           REMAP,
    output logic [NUM_SLAVES-1:0]          HSELS,
    output logic                           HSELDEF,
    input  logic [NUM_SLAVES-1:0]          HREADYOUTS,
    input  logic [2*NUM_SLAVES-1:0]        HRESPS,
    input  logic [DATA_W*NUM_SLAVES-1:0]   HRDATAS,
    output logic                           HREADY,
    output logic [1:0]                     HRESP,
    output logic [DATA_W-1:0]              HRDATA,
    output logic [DECERR_CNT_W-1:0]        DECERR_CNT
);

    logic [3:0]              region;
    logic                    remap_act;
    logic [NUM_SLAVES:0]     dsel;
    logic                    def_hreadyout;
    logic [1:0]              def_hresp;
    logic [DECERR_CNT_W-1:0] decerr_cnt;
    logic [27:0]             unused_haddr_lsb;

    assign region           = HADDR[31:28];
    assign unused_haddr_lsb = HADDR[27:0];

`ifdef AHBMTX_DEC_REMAP_EN
    assign remap_act = REMAP;
`else
    logic unused_remap;
    assign remap_act    = 1'b0;
    assign unused_remap = REMAP;
`endif

    // Priority chain: duplicate bases resolve to the lowest slave index.
    always_comb begin
        HSELS = '0;
        if (remap_act && (region == 4'h0)) begin
            HSELS[1] = 1'b1;
        end else if (region == S0_BASE) begin
            HSELS[0] = 1'b1;
        end else if (region == S1_BASE) begin
            HSELS[1] = 1'b1;
        end else if (region == S2_BASE) begin
            HSELS[2] = 1'b1;
        end else if (region == S3_BASE) begin
            HSELS[3] = 1'b1;
        end
    end

    assign HSELDEF = ~|HSELS;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= 5'b10000;
        end else if (HREADY) begin
            dsel <= {HSELDEF, HSELS};
        end
    end

    AhbMtx_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSELDEF),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (def_hreadyout),
        .HRESP     (def_hresp)
    );

    // dsel is one-hot, so the last matching term is the only one.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                HREADY = HREADYOUTS[i];
                HRESP  = HRESPS[i*2 +: 2];
                HRDATA = HRDATAS[i*DATA_W +: DATA_W];
            end
        end
        if (dsel[NUM_SLAVES]) begin
            HREADY = def_hreadyout;
            HRESP  = def_hresp;
            HRDATA = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            decerr_cnt <= '0;
        end else if (dsel[NUM_SLAVES] && HREADY && (HRESP == HRESP_ERROR) && (decerr_cnt != '1)) begin
            decerr_cnt <= decerr_cnt + 1'b1;
        end
    end

    assign DECERR_CNT = decerr_cnt;

endmodule

// File: tb/tb_ahbmtx_addr_decoder.sv
// Randomized and directed bench for ahbmtx_addr_decoder against a transfer-level model.
module tb_ahbmtx_addr_decoder;

`ifdef AHBMTX_DEC_REMAP_EN
    localparam bit REMAP_ON = 1'b1;
`else
    localparam bit REMAP_ON = 1'b0;
`endif

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         REMAP;
    logic [3:0]   HSELS;
    logic         HSELDEF;
    logic [3:0]   HREADYOUTS;
    logic [7:0]   HRESPS;
    logic [127:0] HRDATAS;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA;
    logic [7:0]   DECERR_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the data phase (0-3 slave, 4 default), error cycles left, error count.
    int m_owner;
    int m_err_left;
    int m_cnt;

    always #5 HCLK = ~HCLK;

    ahbmtx_addr_decoder dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .REMAP      (REMAP),
        .HSELS      (HSELS),
        .HSELDEF    (HSELDEF),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .HRDATAS    (HRDATAS),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .DECERR_CNT (DECERR_CNT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory map with default bases: 0->S0, 2->S1, 4->S2, 5->S3, rest default.
    function automatic int tgt_of(input logic [31:0] a, input logic r);
        logic [3:0] nib;
        nib = a[31:28];
        if (REMAP_ON && r && nib == 4'h0) return 1;
        case (nib)
            4'h0:    return 0;
            4'h2:    return 1;
            4'h4:    return 2;
            4'h5:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_ready();
        if (m_owner < 4) return HREADYOUTS[m_owner];
        return (m_err_left != 2);
    endfunction

    task automatic model_reset();
        m_owner    = 4;
        m_err_left = 0;
        m_cnt      = 0;
    endtask

    task automatic check_model();
        int t;
        logic [3:0]  es;
        logic [1:0]  ep;
        logic [31:0] ed;
        t  = tgt_of(HADDR, REMAP);
        es = '0;
        if (t < 4) es[t] = 1'b1;
        if (m_owner < 4) begin
            ep = HRESPS[m_owner*2 +: 2];
            ed = HRDATAS[m_owner*32 +: 32];
        end else begin
            ep = (m_err_left > 0) ? 2'b01 : 2'b00;
            ed = 32'h0;
        end
        chk("m_hsels",   32'(HSELS),      32'(es));
        chk("m_hseldef", 32'(HSELDEF),    32'(t == 4));
        chk("m_hready",  32'(HREADY),     32'(m_ready()));
        chk("m_hresp",   32'(HRESP),      32'(ep));
        chk("m_hrdata",  HRDATA,          ed);
        chk("m_cnt",     32'(DECERR_CNT), 32'(m_cnt));
    endtask

    task automatic update_model();
        int  t;
        logic rdy;
        t   = tgt_of(HADDR, REMAP);
        rdy = m_ready();
        if (m_owner == 4 && m_err_left == 1 && rdy && m_cnt < 255) m_cnt++;
        if (rdy) begin
            m_owner    = t;
            m_err_left = (t == 4 && HTRANS[1]) ? 2 : 0;
        end else if (m_owner == 4 && m_err_left == 2) begin
            m_err_left = 1;
        end
    endtask

    // Inputs are set at the falling edge; compare, clock the model, return to falling edge.
    task automatic cyc();
        #1;
        check_model();
        @(posedge HCLK);
        update_model();
        @(negedge HCLK);
    endtask

    initial begin
        HRESETn    = 1'b0;
        HADDR      = 32'h0;
        HTRANS     = 2'b00;
        REMAP      = 1'b0;
        HREADYOUTS = 4'hF;
        HRESPS     = 8'h00;
        HRDATAS    = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        #1;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp",  32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_cnt",    32'(DECERR_CNT), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // Read from slave 1.
        HADDR = 32'h2000_0010; HTRANS = 2'b10;
        HRDATAS[63:32] = 32'hDEADBEEF;
        #1 chk("rd_hsels", 32'(HSELS), 32'b0010);
        cyc();
        HADDR = 32'h0; HTRANS = 2'b00;
        #1 chk("rd_hrdata", HRDATA, 32'hDEADBEEF);
        chk("rd_hresp", 32'(HRESP), 32'd0);
        cyc();

        // Unmapped NONSEQ: two-cycle error, counter to 1.
        HADDR = 32'h9000_0000; HTRANS = 2'b10;
        #1 chk("de_hseldef", 32'(HSELDEF), 32'd1);
        cyc();
        HTRANS = 2'b00;
        #1 chk("de_wait_rdy", 32'(HREADY), 32'd0);
        chk("de_wait_resp", 32'(HRESP), 32'd1);
        cyc();
        #1 chk("de_end_rdy", 32'(HREADY), 32'd1);
        chk("de_end_resp", 32'(HRESP), 32'd1);
        cyc();
        #1 chk("de_cnt", 32'(DECERR_CNT), 32'd1);

        // Slave 2 stalls three cycles while the next address targets slave 0.
        HADDR = 32'h4000_0000; HTRANS = 2'b10;
        cyc();
        HADDR = 32'h0000_0040;
        HREADYOUTS = 4'b1011;
        HRDATAS[95:64] = 32'h2222_2222;
        HRDATAS[31:0]  = 32'h0A0A_0A0A;
        for (int k = 0; k < 3; k++) begin
            #1 chk("st_rdy", 32'(HREADY), 32'd0);
            chk("st_data", HRDATA, 32'h2222_2222);
            cyc();
        end
        HREADYOUTS = 4'hF;
        #1 chk("st_rel_data", HRDATA, 32'h2222_2222);
        cyc();
        HTRANS = 2'b00;
        #1 chk("st_s0_data", HRDATA, 32'h0A0A_0A0A);
        cyc();

        // Remap behaviour of region 0.
        HADDR = 32'h0000_0100; REMAP = 1'b1;
        #1 chk("rm_on", 32'(HSELS), REMAP_ON ? 32'b0010 : 32'b0001);
        REMAP = 1'b0;
        #1 chk("rm_off", 32'(HSELS), 32'b0001);
        cyc();

        // Reset during default-slave wait state.
        HADDR = 32'hA000_0000; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        #1 chk("rw_wait", 32'(HREADY), 32'd0);
        HRESETn = 1'b0;
        model_reset();
        #1 chk("rw_rdy",  32'(HREADY), 32'd1);
        chk("rw_resp", 32'(HRESP), 32'd0);
        chk("rw_cnt",  32'(DECERR_CNT), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1 chk("rw_post_rdy", 32'(HREADY), 32'd1);
        chk("rw_post_resp", 32'(HRESP), 32'd0);
        cyc();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] nib;
            case ($urandom_range(0, 5))
                0: nib = 4'h0;
                1: nib = 4'h2;
                2: nib = 4'h4;
                3: nib = 4'h5;
                4: nib = 4'h9;
                default: nib = 4'($urandom_range(0, 15));
            endcase
            HADDR  = {nib, 28'($urandom)};
            HTRANS = 2'($urandom_range(0, 3));
            REMAP  = 1'($urandom_range(0, 1));
            for (int s = 0; s < 4; s++) begin
                HREADYOUTS[s]       = ($urandom_range(0, 3) != 0);
                HRESPS[s*2 +: 2]    = 2'($urandom_range(0, 3));
                HRDATAS[s*32 +: 32] = $urandom;
            end
            cyc();
        end

        // Back-to-back unmapped NONSEQ until the counter saturates.
        REMAP = 1'b0; HREADYOUTS = 4'hF;
        HADDR = 32'h9000_0000; HTRANS = 2'b10;
        repeat (600) cyc();
        HTRANS = 2'b00;
        cyc();
        #1 chk("sat_cnt", 32'(DECERR_CNT), 32'hFF);
        HTRANS = 2'b10;
        repeat (6) cyc();
        HTRANS = 2'b00;
        cyc();
        #1 chk("sat_hold", 32'(DECERR_CNT), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
